// File: rtl/sram_like_arbiter.sv
// Arbitrates the IF and EXE/MEM ports onto one SRAM-like master port and routes in-order responses back.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed data-over-inst priority otherwise.
module sram_like_arbiter #(
    parameter int OST_DEPTH = 4,
    parameter int PTR_W     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] shared_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    typedef enum logic {
        GRANT_IDLE,
        GRANT_HOLD
    } grant_state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OST_DEPTH);

    grant_state_t state, state_nxt;
    logic hold_data, hold_data_nxt;
    logic arb_data;
    logic gnt_data;
    logic side_req;
    logic fifo_full;
    logic hs;
    logic push, pop;
    logic head;

    logic [OST_DEPTH-1:0] id_fifo;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_last = 1 means data won the most recent handshake
    logic rr_last;

    always_comb begin
        arb_data = data_req & (~inst_req | ~rr_last);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr_last <= 1'b0;
        else if (hs)
            rr_last <= gnt_data;
    end
`else
    always_comb begin
        arb_data = data_req;
    end
`endif

    // While holding, the latched side keeps the port so m_* stay stable until addr_ok
    always_comb begin
        gnt_data  = (state == GRANT_HOLD) ? hold_data : arb_data;
        side_req  = gnt_data ? data_req : inst_req;
        fifo_full = (count == FULL_CNT);
        m_req     = side_req & ~fifo_full & resetn;
        hs        = m_req & m_addr_ok;
        push      = hs;
        pop       = m_data_ok & (count != '0);
        head      = id_fifo[rd_ptr];
    end

    always_comb begin
        m_wr         = gnt_data & data_wr;
        m_size       = gnt_data ? data_size  : 2'b10;
        m_wstrb      = gnt_data ? data_wstrb : 4'b0000;
        m_addr       = gnt_data ? data_addr  : inst_addr;
        m_wdata      = gnt_data ? data_wdata : 32'h0;
        inst_addr_ok = hs & ~gnt_data;
        data_addr_ok = hs & gnt_data;
        inst_data_ok = pop & ~head;
        data_data_ok = pop & head;
        shared_rdata = m_rdata;
    end

    always_comb begin
        state_nxt     = state;
        hold_data_nxt = hold_data;
        case (state)
            GRANT_IDLE: begin
                if (m_req && !m_addr_ok) begin
                    state_nxt     = GRANT_HOLD;
                    hold_data_nxt = gnt_data;
                end
            end
            GRANT_HOLD: begin
                if (hs || !side_req)
                    state_nxt = GRANT_IDLE;
            end
            default: state_nxt = GRANT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= GRANT_IDLE;
            hold_data <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_data <= hold_data_nxt;
        end
    end

    // Owner log: pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= gnt_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
